// File: rtl/uart_point_loader_pkg.sv
// Shared definitions for the UART point loader.
// Holds the parser and receiver state encodings, the default frame sync marker,
// the UART frame length in bit-times, and the checksum accumulation helper.
package uart_point_loader_pkg;

   // Frame parser states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_X    = 3'd2,
      ST_Y    = 3'd3,
      ST_CHK  = 3'd4
   } parser_state_e;

   // UART receiver states
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
   // start + 8 data + stop
   localparam int unsigned BITS_PER_FRAME    = 10;

   // Running frame checksum: XOR of the length byte and every coordinate byte
   function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
      return acc ^ data;
   endfunction

endpackage

// File: rtl/uart_point_loader_rx_core.sv
// uart_rx_core: 8N1 UART receiver.
// Synchronises the raw line, times bits from the start-bit falling edge, samples
// mid-bit LSB first and reports each byte whose stop bit is high.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rx           raw serial line (idle high)
//   rx_byte      last correctly framed byte (held until the next one)
//   byte_valid   one-cycle pulse: rx_byte updated
//   rx_err       one-cycle pulse: stop bit sampled low, byte dropped
module uart_rx_core
   import uart_point_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       rx_err
);

   localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic             sync1_q, sync2_q, prev_q;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   // Next-state logic for the bit timer and shift register
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1'b1);
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            // Edge detect rather than level so a line still low after a bad
            // stop bit is not taken as a new start bit.
            if (prev_q && !sync2_q) begin
               state_d = RX_START;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = {CNT_W{1'b0}};
               bit_d = 3'd0;
               // Start bit gone high again by mid-bit: a glitch, drop silently
               if (sync2_q) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d = RX_DATA;
               end
            end else begin
               state_d = RX_START;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = {CNT_W{1'b0}};
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  state_d = RX_DATA;
               end
            end else begin
               state_d = RX_DATA;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = RX_IDLE;
               if (sync2_q) begin
                  valid_d = 1'b1;
                  byte_d  = shift_q;
               end else begin
                  err_d   = 1'b1;
               end
            end else begin
               state_d = RX_STOP;
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Receiver registers; synchroniser presets to idle-high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         byte_q  <= 8'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign rx_byte    = byte_q;
   assign byte_valid = valid_q;
   assign rx_err     = err_q;

endmodule

// File: rtl/uart_point_loader.sv
// uart_point_loader: parses framed (x,y) point lists arriving over 8N1 UART and
// emits one-cycle point-RAM writes plus the length of the last good frame.
// Frame: SYNC, N, N pairs (X,Y), CHK = XOR of N and all coordinate bytes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       0 holds the parser in IDLE (bytes still received, then discarded)
//   uart_rx      raw serial line
//   pt_we        one-cycle point write strobe; pt_addr/pt_x/pt_y hold otherwise
//   frame_len    point count of the last good frame (0 = none yet)
//   frame_done   one-cycle pulse on checksum match
//   frame_err    one-cycle pulse on bad length/checksum/stop bit/timeout
//   busy         parser not in IDLE
module uart_point_loader
   import uart_point_loader_pkg::*;
#(
   parameter int         CLKS_PER_BIT  = 87,
   parameter int         ADDR_W        = 5,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              uart_rx,
   output logic              pt_we,
   output logic [ADDR_W-1:0] pt_addr,
   output logic [7:0]        pt_x,
   output logic [7:0]        pt_y,
   output logic [ADDR_W:0]   frame_len,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   localparam int              N_W         = ADDR_W + 1;
   localparam int              DEPTH       = 1 << ADDR_W;
   localparam int              TO_LIMIT    = TIMEOUT_BYTES * int'(BITS_PER_FRAME) * CLKS_PER_BIT;
   localparam int              TO_W        = $clog2(TO_LIMIT + 1);
   localparam logic [TO_W-1:0] TO_LIMIT_M1 = TO_W'(TO_LIMIT - 1);

   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       rx_err;
   logic       timeout_s;

   parser_state_e     state_q, state_d;
   logic [N_W-1:0]    n_q, n_d;
   logic [N_W-1:0]    idx_q, idx_d;
   logic [7:0]        chk_q, chk_d;
   logic [7:0]        x_q, x_d;
   logic [7:0]        y_q, y_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              wr_pend_q, wr_pend_d;
   logic              pt_we_q, pt_we_d;
   logic [ADDR_W-1:0] pt_addr_q, pt_addr_d;
   logic [7:0]        pt_x_q, pt_x_d;
   logic [7:0]        pt_y_q, pt_y_d;
   logic [N_W-1:0]    frame_len_q, frame_len_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (uart_rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .rx_err     (rx_err)
   );

   assign timeout_s = (state_q != ST_IDLE) && (to_cnt_q == TO_LIMIT_M1);

   // Parser next state, checksum, point index, timeout and output strobes
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      idx_d        = idx_q;
      chk_d        = chk_q;
      x_d          = x_q;
      y_d          = y_q;
      wr_pend_d    = 1'b0;
      pt_we_d      = 1'b0;
      pt_addr_d    = pt_addr_q;
      pt_x_d       = pt_x_q;
      pt_y_d       = pt_y_q;
      frame_len_d  = frame_len_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;

      // The point write is issued one cycle after the Y byte is parsed, which
      // puts pt_we two clocks after the stop-bit sample; the index advances with it.
      if (wr_pend_q) begin
         pt_we_d   = 1'b1;
         pt_addr_d = idx_q[ADDR_W-1:0];
         pt_x_d    = x_q;
         pt_y_d    = y_q;
         idx_d     = idx_q + N_W'(1'b1);
      end else begin
         pt_we_d   = 1'b0;
      end

      // Error priority: rx_err > timeout > content check
      if (!enable) begin
         state_d = ST_IDLE;
      end else if (rx_err && (state_q != ST_IDLE)) begin
         frame_err_d = 1'b1;
         state_d     = ST_IDLE;
      end else if (timeout_s) begin
         frame_err_d = 1'b1;
         state_d     = ST_IDLE;
      end else if (byte_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == SYNC_BYTE) begin
                  state_d = ST_LEN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LEN: begin
               if ((rx_byte == 8'd0) || (int'(rx_byte) > DEPTH)) begin
                  frame_err_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  n_d     = N_W'(rx_byte);
                  idx_d   = {N_W{1'b0}};
                  chk_d   = rx_byte;
                  state_d = ST_X;
               end
            end
            ST_X: begin
               x_d     = rx_byte;
               chk_d   = chk_update(chk_q, rx_byte);
               state_d = ST_Y;
            end
            ST_Y: begin
               y_d       = rx_byte;
               chk_d     = chk_update(chk_q, rx_byte);
               wr_pend_d = 1'b1;
               // idx still names this point; its increment comes with the write
               if ((idx_q + N_W'(1'b1)) == n_q) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_X;
               end
            end
            ST_CHK: begin
               if (rx_byte == chk_q) begin
                  frame_len_d  = n_q;
                  frame_done_d = 1'b1;
               end else begin
                  frame_err_d  = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      // Idle time inside a frame; cleared by every received byte
      if (byte_valid || (state_d == ST_IDLE)) begin
         to_cnt_d = {TO_W{1'b0}};
      end else begin
         to_cnt_d = to_cnt_q + TO_W'(1'b1);
      end

      busy_d = (state_d != ST_IDLE);
   end

   // Parser state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         n_q          <= {N_W{1'b0}};
         idx_q        <= {N_W{1'b0}};
         chk_q        <= 8'd0;
         x_q          <= 8'd0;
         y_q          <= 8'd0;
         to_cnt_q     <= {TO_W{1'b0}};
         wr_pend_q    <= 1'b0;
         pt_we_q      <= 1'b0;
         pt_addr_q    <= {ADDR_W{1'b0}};
         pt_x_q       <= 8'd0;
         pt_y_q       <= 8'd0;
         frame_len_q  <= {N_W{1'b0}};
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         idx_q        <= idx_d;
         chk_q        <= chk_d;
         x_q          <= x_d;
         y_q          <= y_d;
         to_cnt_q     <= to_cnt_d;
         wr_pend_q    <= wr_pend_d;
         pt_we_q      <= pt_we_d;
         pt_addr_q    <= pt_addr_d;
         pt_x_q       <= pt_x_d;
         pt_y_q       <= pt_y_d;
         frame_len_q  <= frame_len_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
      end
   end

   assign pt_we      = pt_we_q;
   assign pt_addr    = pt_addr_q;
   assign pt_x       = pt_x_q;
   assign pt_y       = pt_y_q;
   assign frame_len  = frame_len_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_point_loader.sv
// Self-checking bench for uart_point_loader (CLKS_PER_BIT=4, ADDR_W=2).
// A frame-level reference parser turns each delivered byte list into an ordered
// list of expected events (point writes, done, error); a monitor on every falling
// edge matches DUT strobes against that list and frame_len against the model.
module tb_uart_point_loader;

   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int TOB   = 4;

   localparam int EV_WR   = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          enable  = 1'b0;
   logic          uart_rx = 1'b1;
   logic          pt_we;
   logic [AW-1:0] pt_addr;
   logic [7:0]    pt_x;
   logic [7:0]    pt_y;
   logic [AW:0]   frame_len;
   logic          frame_done;
   logic          frame_err;
   logic          busy;

   typedef struct {
      int kind;
      int addr;
      int x;
      int y;
      int len;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_ev;
   int  model_len  = 0;
   int  checks     = 0;
   int  errors     = 0;
   int  cyc        = 0;
   int  we_cyc     = 0;
   int  last_start = 0;

   uart_point_loader #(
      .CLKS_PER_BIT  (CPB),
      .ADDR_W        (AW),
      .SYNC_BYTE     (8'hA5),
      .TIMEOUT_BYTES (TOB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .uart_rx    (uart_rx),
      .pt_we      (pt_we),
      .pt_addr    (pt_addr),
      .pt_x       (pt_x),
      .pt_y       (pt_y),
      .frame_len  (frame_len),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int head_kind();
      if (exp_q.size() > 0) return exp_q[0].kind;
      return -1;
   endfunction

   // Reference parser over a whole delivered frame (SYNC first). 'aborted' means
   // the frame was cut short by a stop-bit error or by silence.
   function automatic void model_frame(input logic [7:0] fr[$], input bit aborted);
      int         n;
      logic [7:0] c;
      n = int'(fr[1]);
      if (n == 0 || n > DEPTH) begin
         exp_q.push_back('{EV_ERR, 0, 0, 0, 0});
         return;
      end
      c = fr[1];
      for (int i = 0; i < n; i++) begin
         if (3 + 2 * i < fr.size()) begin
            exp_q.push_back('{EV_WR, i, int'(fr[2 + 2 * i]), int'(fr[3 + 2 * i]), 0});
            c = c ^ fr[2 + 2 * i] ^ fr[3 + 2 * i];
         end
      end
      if (aborted) begin
         exp_q.push_back('{EV_ERR, 0, 0, 0, 0});
      end else if (fr[2 + 2 * n] == c) begin
         exp_q.push_back('{EV_DONE, 0, 0, 0, n});
      end else begin
         exp_q.push_back('{EV_ERR, 0, 0, 0, 0});
      end
   endfunction

   // Monitor: every strobe must match the head of the expected-event list
   always @(negedge clk) begin
      if (rst_n) begin
         if (pt_we) begin
            we_cyc = cyc;
            chk("pt_we_expected", head_kind(), EV_WR);
            if (head_kind() == EV_WR) begin
               mon_ev = exp_q.pop_front();
               chk("pt_addr", int'(pt_addr), mon_ev.addr);
               chk("pt_x", int'(pt_x), mon_ev.x);
               chk("pt_y", int'(pt_y), mon_ev.y);
            end
         end
         if (frame_done) begin
            chk("frame_done_expected", head_kind(), EV_DONE);
            if (head_kind() == EV_DONE) begin
               mon_ev    = exp_q.pop_front();
               model_len = mon_ev.len;
            end
         end
         if (frame_err) begin
            chk("frame_err_expected", head_kind(), EV_ERR);
            if (head_kind() == EV_ERR) begin
               mon_ev = exp_q.pop_front();
            end
         end
         chk("done_err_exclusive", int'(frame_done & frame_err), 0);
         chk("frame_len", int'(frame_len), model_len);
      end
   end

   task automatic drive_bit(input logic v);
      @(posedge clk);
      #1 uart_rx = v;
      repeat (CPB - 1) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      @(posedge clk);
      #1 uart_rx = 1'b0;
      last_start = cyc;
      repeat (CPB - 1) @(posedge clk);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
      if (!stop) drive_bit(1'b1);
   endtask

   task automatic send_list(input logic [7:0] fr[$]);
      foreach (fr[i]) send_byte(fr[i], 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pt_we"}, int'(pt_we), 0);
      chk({tag, "_pt_addr"}, int'(pt_addr), 0);
      chk({tag, "_pt_x"}, int'(pt_x), 0);
      chk({tag, "_pt_y"}, int'(pt_y), 0);
      chk({tag, "_frame_len"}, int'(frame_len), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_frame_err"}, int'(frame_err), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      logic [7:0] fr[$];
      logic [7:0] c;
      logic [7:0] b;
      int         n;
      int         kind;
      int         y_start;

      // Reset state
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      rst_n  = 1'b1;
      enable = 1'b1;
      idle(5);

      // Good frame: two points, checksum 0x42
      fr = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h42};
      model_frame(fr, 1'b0);
      chk("model_events_frame1", exp_q.size(), 3);
      for (int i = 0; i < 5; i++) send_byte(fr[i], 1'b1);
      send_byte(fr[5], 1'b1);
      y_start = last_start;
      send_byte(fr[6], 1'b1);
      idle(20);
      chk("frame1_len_literal", int'(frame_len), 2);
      chk("pt_we_latency", we_cyc - y_start, 43);
      chk("frame1_busy", int'(busy), 0);

      // Same frame, wrong checksum: writes still happen, length unchanged
      fr = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h43};
      model_frame(fr, 1'b0);
      send_list(fr);
      idle(20);
      chk("badchk_len_literal", int'(frame_len), 2);

      // Bad lengths 0 and 5
      fr = '{8'hA5, 8'h00};
      model_frame(fr, 1'b0);
      send_list(fr);
      idle(20);
      chk("len0_busy", int'(busy), 0);
      fr = '{8'hA5, 8'h05};
      model_frame(fr, 1'b0);
      send_list(fr);
      idle(20);
      chk("len5_busy", int'(busy), 0);
      chk("len_err_drained", exp_q.size(), 0);

      // One-clock glitch in idle, then a good frame
      @(posedge clk);
      #1 uart_rx = 1'b0;
      @(posedge clk);
      #1 uart_rx = 1'b1;
      idle(60);
      chk("glitch_busy", int'(busy), 0);
      fr = '{8'hA5, 8'h01, 8'h77, 8'h88, 8'h01 ^ 8'h77 ^ 8'h88};
      model_frame(fr, 1'b0);
      send_list(fr);
      idle(20);
      chk("glitch_frame_len", int'(frame_len), 1);

      // Stop bit low on the third byte
      fr = '{8'hA5, 8'h01};
      model_frame(fr, 1'b1);
      send_list(fr);
      send_byte(8'h10, 1'b0);
      idle(20);
      chk("stoperr_busy", int'(busy), 0);
      chk("stoperr_drained", exp_q.size(), 0);
      fr = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04};
      model_frame(fr, 1'b0);
      send_list(fr);
      idle(20);
      chk("after_stoperr_len", int'(frame_len), 2);

      // Silence mid-frame: 160-clock timeout
      fr = '{8'hA5, 8'h01, 8'h10};
      model_frame(fr, 1'b1);
      send_list(fr);
      idle(100);
      chk("timeout_still_busy", int'(busy), 1);
      idle(100);
      chk("timeout_busy", int'(busy), 0);
      chk("timeout_drained", exp_q.size(), 0);

      // Enable dropped mid-frame
      fr = '{8'hA5, 8'h01};
      send_list(fr);
      idle(4);
      chk("enable_busy_before", int'(busy), 1);
      @(posedge clk);
      #1 enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("enable_busy_after", int'(busy), 0);
      fr = '{8'h10, 8'h20, 8'h31};
      send_list(fr);
      idle(20);
      chk("enable_drained", exp_q.size(), 0);
      @(posedge clk);
      #1 enable = 1'b1;
      idle(5);

      // Randomized frames with junk in between
      for (int it = 0; it < 30; it++) begin
         for (int j = 0; j < $urandom_range(0, 2); j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, 1'b1);
         end
         kind = $urandom_range(0, 9);
         fr = '{8'hA5};
         if (kind == 9) begin
            n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 255);
            fr.push_back(8'(n));
         end else begin
            n = $urandom_range(1, DEPTH);
            fr.push_back(8'(n));
            c = 8'(n);
            for (int k = 0; k < 2 * n; k++) begin
               b = 8'($urandom_range(0, 255));
               fr.push_back(b);
               c = c ^ b;
            end
            if (kind >= 7) c = c ^ 8'($urandom_range(1, 255));
            fr.push_back(c);
         end
         model_frame(fr, 1'b0);
         send_list(fr);
         idle(20);
         chk("rand_busy", int'(busy), 0);
         chk("rand_drained", exp_q.size(), 0);
      end

      // Known frame, then reset in the middle of a byte
      fr = '{8'hA5, 8'h01, 8'h5C, 8'h3E, 8'h01 ^ 8'h5C ^ 8'h3E};
      model_frame(fr, 1'b0);
      send_list(fr);
      idle(20);
      chk("pre_reset_len", int'(frame_len), 1);
      send_byte(8'hA5, 1'b1);
      @(posedge clk);
      #1 uart_rx = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midbyte_reset");
      exp_q.delete();
      model_len = 0;
      uart_rx   = 1'b1;
      idle(3);
      #1 rst_n = 1'b1;
      idle(10);
      fr = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
             8'h03 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06};
      model_frame(fr, 1'b0);
      send_list(fr);
      idle(20);
      chk("post_reset_len", int'(frame_len), 3);
      chk("final_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
